decode_queue: RTL and testbench

Registered RV32I/RV64I instruction-decode stage for the multi-cycle core. Accepts fetched instructions with their PC over a valid/ready handshake, decodes opcode, register fields, immediate-format select and sign-extended immediate in the same cycle, and stores each decoded record in a parametrised FIFO. The execute/control FSM pops records over a second handshake. Illegal encodings are flagged per record and counted. A synchronous flush supports redirects.

---
 rtl/decode_queue.sv | 181 ++++++++++++++++++
 tb/tb_decode_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32I/RV64I decode stage: decodes each fetched instruction on entry and
// buffers the decoded record in a DEPTH-entry FIFO for the execute/control FSM.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [2:0]       out_sel_ext,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_U = 3'b011;
  localparam logic [2:0] SEL_J = 3'b100;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      sel_ext;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  rec_t               dec_rec;
  logic signed [31:0] imm32;
  logic [2:0]         sel;
  logic               legal;
  logic               push;
  logic               pop;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready never looks at out_ready, so a full queue accepts a
  // new entry only the cycle after a pop; flush blocks both sides.
  assign in_ready  = (count_q < DEPTH_C) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  // Immediates are assembled as signed 32-bit values, then sign-extended.
  always_comb begin
    sel   = SEL_I;
    imm32 = '0;
    legal = 1'b1;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        sel   = SEL_I;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        sel   = SEL_S;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        sel   = SEL_B;
        imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        sel   = SEL_U;
        imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        sel   = SEL_J;
        imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        sel   = SEL_I;
        imm32 = '0;
      end
      default: legal = 1'b0;
    endcase
    if (in_instr[1:0] != 2'b11) legal = 1'b0;
    if (!legal) begin
      sel   = SEL_I;
      imm32 = '0;
    end
  end

  always_comb begin
    dec_rec.opcode  = in_instr[6:0];
    dec_rec.rd      = in_instr[11:7];
    dec_rec.rs1     = in_instr[19:15];
    dec_rec.rs2     = in_instr[24:20];
    dec_rec.funct3  = in_instr[14:12];
    dec_rec.funct7  = in_instr[31:25];
    dec_rec.sel_ext = sel;
    dec_rec.imm     = XLEN'(imm32);
    dec_rec.pc      = in_pc;
    dec_rec.illegal = !legal;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // Saturating: the counter holds at all-ones; flush leaves it alone.
    if (push && !legal && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ill_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
      if (push) mem_q[wr_ptr_q] <= dec_rec;
    end
  end

  rec_t head;
  assign head        = mem_q[rd_ptr_q];
  assign out_opcode  = head.opcode;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_sel_ext = head.sel_ext;
  assign out_imm     = head.imm;
  assign out_pc      = head.pc;
  assign out_illegal = head.illegal;
  assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed cases plus randomized traffic checked
// against a queue-based reference model; a second instance uses a 2-bit counter.
module tb_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            ill;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_ready = 1'b0;
  logic            in_ready, out_valid, out_illegal;
  logic [6:0]      out_opcode, out_funct7;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3, out_sel_ext;
  logic [XLEN-1:0] out_imm, out_pc;
  logic [15:0]     illegal_cnt;

  logic            s_in_ready, s_out_valid, s_out_illegal;
  logic [6:0]      s_out_opcode, s_out_funct7;
  logic [4:0]      s_out_rd, s_out_rs1, s_out_rs2;
  logic [2:0]      s_out_funct3, s_out_sel_ext;
  logic [XLEN-1:0] s_out_imm, s_out_pc;
  logic [1:0]      s_illegal_cnt;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_sel_ext(out_sel_ext),
    .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_opcode(s_out_opcode), .out_rd(s_out_rd), .out_rs1(s_out_rs1),
    .out_rs2(s_out_rs2), .out_funct3(s_out_funct3), .out_funct7(s_out_funct7),
    .out_sel_ext(s_out_sel_ext), .out_imm(s_out_imm), .out_pc(s_out_pc),
    .out_illegal(s_out_illegal), .illegal_cnt(s_illegal_cnt)
  );

  // clock
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  rec_t exp_q[$];
  int   ill_n = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decoder: immediates built as integer weights, minus 2^n if negative.
  function automatic rec_t ref_decode(input logic [31:0] w, input logic [XLEN-1:0] pc);
    rec_t   r;
    longint v;
    int     kind;
    r.opcode = w[6:0];
    r.rd     = w[11:7];
    r.rs1    = w[19:15];
    r.rs2    = w[24:20];
    r.funct3 = w[14:12];
    r.funct7 = w[31:25];
    r.pc     = pc;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: kind = 0;
      7'h23: kind = 1;
      7'h63: kind = 2;
      7'h37, 7'h17: kind = 3;
      7'h6F: kind = 4;
      7'h33: kind = 5;
      default: kind = -1;
    endcase
    if (w[1:0] != 2'b11) kind = -1;
    v = 0;
    case (kind)
      0: v = longint'(w[31:20]) - (w[31] ? 4096 : 0);
      1: v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 4096 : 0);
      2: v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
             + longint'(w[11:8]) * 2 - (w[31] ? 8192 : 0);
      3: v = longint'(w[31:12]) * 4096 - (w[31] ? 64'sh1_0000_0000 : 64'sh0);
      4: v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
             + longint'(w[30:21]) * 2 - (w[31] ? 2097152 : 0);
      default: v = 0;
    endcase
    r.imm = v[XLEN-1:0];
    r.sel = (kind >= 0 && kind <= 4) ? 3'(kind) : 3'b000;
    r.ill = (kind < 0);
    return r;
  endfunction

  task automatic check_outputs();
    rec_t h;
    int   sat16, sat2;
    check_eq("in_ready", in_ready, (exp_q.size() < DEPTH) && !flush);
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check_eq("opcode", out_opcode, h.opcode);
      check_eq("rd", out_rd, h.rd);
      check_eq("rs1", out_rs1, h.rs1);
      check_eq("rs2", out_rs2, h.rs2);
      check_eq("funct3", out_funct3, h.funct3);
      check_eq("funct7", out_funct7, h.funct7);
      check_eq("sel_ext", out_sel_ext, h.sel);
      check_eq("imm", out_imm, h.imm);
      check_eq("pc", out_pc, h.pc);
      check_eq("illegal", out_illegal, h.ill);
    end
    sat16 = (ill_n > 65535) ? 65535 : ill_n;
    sat2  = (ill_n > 3) ? 3 : ill_n;
    check_eq("illegal_cnt", illegal_cnt, 64'(sat16));
    check_eq("illegal_cnt_sat", s_illegal_cnt, 64'(sat2));
  endtask

  // Driver: apply one cycle of inputs, check, then advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                      input logic ordy, input logic fl);
    logic exp_rdy, push, pop;
    rec_t r;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    check_outputs();
    exp_rdy = (exp_q.size() < DEPTH) && !fl;
    push    = v && exp_rdy;
    pop     = (exp_q.size() != 0) && ordy && !fl;
    r       = ref_decode(ins, pc);
    if (fl) exp_q.delete();
    else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(r);
    end
    if (push && r.ill) ill_n++;
  endtask

  logic [31:0] seq_ins [5] = '{32'h0020A423, 32'hFE000EE3, 32'h001000EF, 32'h123452B7, 32'h0020C0B3};
  logic [2:0]  seq_sel [5] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b000};
  logic [31:0] seq_imm [5] = '{32'h8, 32'hFFFFFFFC, 32'h800, 32'h12345000, 32'h0};
  logic [6:0]  ops [11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic [31:0] r32, ins;
    // reset block
    #3;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_opcode", out_opcode, 0);
    check_eq("rst_imm", out_imm, 0);
    check_eq("rst_pc", out_pc, 0);
    check_eq("rst_cnt", illegal_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,-1
    step(1, 32'hFFF00093, 32'h100, 1, 0);
    step(0, 0, 0, 1, 0);
    check_eq("addi_valid", out_valid, 1);
    check_eq("addi_opcode", out_opcode, 7'b0010011);
    check_eq("addi_rd", out_rd, 1);
    check_eq("addi_rs1", out_rs1, 0);
    check_eq("addi_sel", out_sel_ext, 0);
    check_eq("addi_imm", out_imm, 32'hFFFFFFFF);
    check_eq("addi_pc", out_pc, 32'h100);
    check_eq("addi_ill", out_illegal, 0);

    // format sequence, popped as they arrive
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) step(1, seq_ins[i], 32'h200 + 32'(4 * i), 1, 0);
      else       step(0, 0, 0, 1, 0);
      if (i > 0) begin
        check_eq("seq_sel", out_sel_ext, seq_sel[i-1]);
        check_eq("seq_imm", out_imm, seq_imm[i-1]);
        if (i == 3) check_eq("jal_rd", out_rd, 1);
        if (i == 4) check_eq("lui_rd", out_rd, 5);
        if (i == 5) check_eq("xor_funct3", out_funct3, 3'b100);
      end
    end
    step(0, 0, 0, 1, 0);

    // illegal encodings and counter saturation
    step(1, 32'h00000000, 32'h300, 1, 0);
    step(1, 32'h0000007F, 32'h304, 1, 0);
    check_eq("ill0_flag", out_illegal, 1);
    step(0, 0, 0, 1, 0);
    check_eq("ill1_flag", out_illegal, 1);
    check_eq("ill1_sel", out_sel_ext, 0);
    check_eq("ill1_imm", out_imm, 0);
    check_eq("ill_cnt_2", illegal_cnt, 2);
    step(1, 32'h00000000, 0, 1, 0);
    step(1, 32'h00000000, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check_eq("ill_cnt_4", illegal_cnt, 4);
    check_eq("ill_cnt_sat3", s_illegal_cnt, 3);

    // full: exactly DEPTH pushes with consumer stalled
    for (int i = 0; i < 4; i++) step(1, 32'h00100093 + 32'(i << 20), 32'h400 + 32'(4 * i), 0, 0);
    check_eq("full_in_ready", in_ready, 0);
    step(0, 0, 0, 1, 0);
    check_eq("full_pop_in_ready", in_ready, 0);
    step(0, 0, 0, 1, 0);
    check_eq("after_pop_in_ready", in_ready, 1);
    step(0, 0, 0, 1, 0);

    // flush with simultaneous push and pop
    step(1, 32'h00500113, 32'h500, 0, 0);
    step(1, 32'h00600113, 32'h504, 0, 0);
    step(1, 32'h00700113, 32'h508, 1, 1);
    step(0, 0, 0, 1, 0);
    check_eq("flush_out_valid", out_valid, 0);
    check_eq("flush_in_ready", in_ready, 1);

    // asynchronous reset with the queue full
    step(1, 32'h00000001, 32'h600, 0, 0);
    step(1, 32'h00800113, 32'h604, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00900113; out_ready = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_opcode", out_opcode, 0);
    check_eq("arst_rd", out_rd, 0);
    check_eq("arst_imm", out_imm, 0);
    check_eq("arst_pc", out_pc, 0);
    check_eq("arst_illegal", out_illegal, 0);
    check_eq("arst_cnt", illegal_cnt, 0);
    check_eq("arst_in_ready", in_ready, 1);
    exp_q.delete();
    ill_n = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      r32 = $urandom();
      if ($urandom_range(0, 4) != 0) ins = {r32[31:7], ops[$urandom_range(0, 10)]};
      else                           ins = $urandom();
      step(1'($urandom_range(0, 3) != 0), ins, XLEN'($urandom()),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
